// File: rtl/i2c_reg_slave.sv
// Two-wire register slave: oversampled, glitch-filtered SCL/SDA, 7-bit address match,
// pointer-addressed burst write/read into a register file with a core-side read-back port.

module i2c_line_filt #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic filt
);
  logic [1:0] sync;
  logic [2:0] run;

  // level is accepted only after FILT_LEN consecutive samples disagree with it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync <= 2'b11;
      run  <= '0;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == filt)                 run <= '0;
      else if (run == 3'(FILT_LEN - 1)) begin
        filt <= sync[1];
        run  <= '0;
      end else                             run <= run + 3'd1;
    end
  end
endmodule

module i2c_reg_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h1D,
  parameter int         NUM_REGS   = 16,
  parameter int         FILT_LEN   = 3,
  parameter logic [7:0] RESET_VAL  = 8'h00,
  localparam int        PW         = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          scl,
  input  logic          sda_in,
  output logic          sda_out,
  output logic          wr_stb,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic [PW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          busy
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;

  state_t        state, state_n;
  logic [1:0]    raw, filt;
  logic          scl_f, sda_f, scl_p, sda_p;
  logic          scl_rise, scl_fall, start, stop;
  logic [3:0]    cnt;
  logic [7:0]    sr, byte_in;
  logic [PW-1:0] ptr, ptr_inc;
  logic [7:0]    regs [NUM_REGS];

  assign raw = {scl, sda_in};
  for (genvar i = 0; i < 2; i++) begin : g_filt
    i2c_line_filt #(.FILT_LEN(FILT_LEN)) u_filt (
      .clk(clk), .reset_n(reset_n), .raw(raw[i]), .filt(filt[i])
    );
  end
  assign scl_f = filt[1];
  assign sda_f = filt[0];

  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;
  assign start    = scl_f & scl_p & sda_p & ~sda_f;
  assign stop     = scl_f & scl_p & ~sda_p & sda_f;

  assign byte_in = {sr[6:0], sda_f};
  assign ptr_inc = (ptr == PW'(NUM_REGS - 1)) ? '0 : ptr + PW'(1);
  assign rd_data = regs[rd_addr];

  always_comb begin
    state_n = state;
    if (start)     state_n = ADDR;
    else if (stop) state_n = IDLE;
    else begin
      case (state)
        ADDR:      if (scl_rise && cnt == 4'd7)
                     state_n = (byte_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : IDLE;
        ADDR_ACK:  if (scl_fall && !sda_out) state_n = sr[0] ? RDATA : PTR;
        PTR:       if (scl_rise && cnt == 4'd7) state_n = PTR_ACK;
        PTR_ACK:   if (scl_fall && !sda_out) state_n = WDATA;
        WDATA:     if (scl_rise && cnt == 4'd7) state_n = WDATA_ACK;
        WDATA_ACK: if (scl_fall && !sda_out) state_n = WDATA;
        RDATA:     if (scl_fall && cnt == 4'd8) state_n = RACK;
        RACK:      if (scl_rise) state_n = sda_f ? IDLE : RDATA;
        default:   state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      scl_p   <= 1'b1;
      sda_p   <= 1'b1;
      sda_out <= 1'b1;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      cnt     <= '0;
      sr      <= '0;
      ptr     <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      state  <= state_n;
      scl_p  <= scl_f;
      sda_p  <= sda_f;
      wr_stb <= 1'b0;
      // bus conditions pre-empt any bit event in the same clk
      if (start) begin
        cnt     <= '0;
        sda_out <= 1'b1;
        busy    <= 1'b0;
      end else if (stop) begin
        sda_out <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: if (scl_rise) begin
            sr  <= byte_in;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              if (state == ADDR && byte_in[7:1] == SLAVE_ADDR) busy <= 1'b1;
              if (state == PTR) ptr <= byte_in[PW-1:0];
              if (state == WDATA) begin
                regs[ptr] <= byte_in;
                wr_stb    <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= byte_in;
              end
            end
          end
          // first fall after the byte drives ACK, second fall ends the 9th clock
          ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
            if (sda_out) sda_out <= 1'b0;
            else begin
              sda_out <= 1'b1;
              cnt     <= '0;
              if (state == WDATA_ACK) ptr <= ptr_inc;
              if (state == ADDR_ACK && sr[0]) begin
                sda_out <= regs[ptr][7];
                sr      <= {regs[ptr][6:0], 1'b1};
              end
            end
          end
          RDATA: begin
            if (scl_rise) cnt <= cnt + 4'd1;
            else if (scl_fall) begin
              if (cnt == 4'd0) begin
                sda_out <= regs[ptr][7];
                sr      <= {regs[ptr][6:0], 1'b1};
              end else if (cnt == 4'd8) begin
                sda_out <= 1'b1;
                cnt     <= '0;
              end else begin
                sda_out <= sr[7];
                sr      <= {sr[6:0], 1'b1};
              end
            end
          end
          RACK: if (scl_rise) begin
            if (!sda_f) begin
              ptr <= ptr_inc;
              cnt <= '0;
            end else busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
